// File: rtl/matvec_mul_fold.sv
// matvec_mul_fold: folded streaming signed matrix-vector multiplier, y = K*x.
// The vector x arrives in beats of P lanes. Each beat goes through registered
// per-row multipliers and a registered adder tree. A per-row accumulator then
// sums the beats and loads a valid/ready output register. A single global
// enable freezes the whole pipeline while the output is stalled.
module matvec_mul_fold #(
  parameter  int R     = 8,
  parameter  int C     = 8,
  parameter  int P     = 4,
  parameter  int W_X   = 8,
  parameter  int W_K   = 8,
  localparam int BEATS = C / P,
  localparam int DP    = $clog2(P),
  localparam int W_M   = W_X + W_K,
  localparam int W_Y   = W_M + $clog2(C)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic signed [R-1:0][C-1:0][W_K-1:0] k,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic signed [P-1:0][W_X-1:0]       s_x,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic signed [R-1:0][W_Y-1:0]       m_y
);

  // Lane count padded to a power of two so every tree level pairs cleanly.
  localparam int PP = 1 << DP;
  localparam int WB = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic                  w_en;
  logic                  w_acc;
  logic                  w_first;
  logic                  w_last;
  logic [WB-1:0]         r_b;
  logic signed [W_Y-1:0] w_prod [R][PP];
  logic signed [W_Y-1:0] r_tree [DP+1][R][PP];
  logic [DP:0]           r_vld;
  logic [DP:0]           r_first;
  logic [DP:0]           r_last;
  logic signed [W_Y-1:0] r_acc  [R];
  logic signed [R-1:0][W_Y-1:0] r_y;
  logic                  r_mvalid;

  assign w_en    = !r_mvalid || m_ready;
  assign s_ready = w_en;
  assign w_acc   = s_valid && w_en;
  assign w_first = (r_b == '0);
  assign w_last  = (r_b == WB'(BEATS - 1));
  assign m_valid = r_mvalid;
  assign m_y     = r_y;

  // Multiply the current beat's K columns by the incoming lanes.
  // The column block is picked by comparing against every beat index, so all
  // selects into k stay constant; padded lanes stay zero.
  always_comb begin
    for (int unsigned r = 0; r < R; r++) begin
      for (int unsigned p = 0; p < PP; p++) begin
        w_prod[r][p] = '0;
      end
    end
    for (int unsigned r = 0; r < R; r++) begin
      for (int unsigned p = 0; p < P; p++) begin
        for (int unsigned bb = 0; bb < BEATS; bb++) begin
          if (r_b == WB'(bb)) begin
            w_prod[r][p] = W_Y'(W_M'($signed(k[r][bb*P+p])) * W_M'($signed(s_x[p])));
          end
        end
      end
    end
  end

  // Beat counter: advances on each accepted beat and wraps after the last one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_b <= '0;
    end else if (w_acc) begin
      r_b <= w_last ? '0 : r_b + 1'b1;
    end
  end

  // Product register and adder-tree levels, with valid/first/last riding alongside.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld   <= '0;
      r_first <= '0;
      r_last  <= '0;
      for (int unsigned l = 0; l <= DP; l++) begin
        for (int unsigned r = 0; r < R; r++) begin
          for (int unsigned p = 0; p < PP; p++) begin
            r_tree[l][r][p] <= '0;
          end
        end
      end
    end else if (w_en) begin
      r_vld[0]   <= s_valid;
      r_first[0] <= w_first;
      r_last[0]  <= w_last;
      for (int unsigned r = 0; r < R; r++) begin
        for (int unsigned p = 0; p < PP; p++) begin
          r_tree[0][r][p] <= w_prod[r][p];
        end
      end
      for (int unsigned l = 1; l <= DP; l++) begin
        r_vld[l]   <= r_vld[l-1];
        r_first[l] <= r_first[l-1];
        r_last[l]  <= r_last[l-1];
        for (int unsigned r = 0; r < R; r++) begin
          for (int unsigned i = 0; i < (PP >> l); i++) begin
            r_tree[l][r][i] <= r_tree[l-1][r][2*i] + r_tree[l-1][r][2*i+1];
          end
          for (int unsigned i = (PP >> l); i < PP; i++) begin
            r_tree[l][r][i] <= '0;
          end
        end
      end
    end
  end

  // Accumulate tree sums across beats and load the output register on the last beat.
  // A handshake with no new result clears m_valid; a same-cycle completion keeps it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mvalid <= 1'b0;
      r_y      <= '0;
      for (int unsigned r = 0; r < R; r++) begin
        r_acc[r] <= '0;
      end
    end else if (w_en) begin
      r_mvalid <= r_vld[DP] && r_last[DP];
      if (r_vld[DP]) begin
        for (int unsigned r = 0; r < R; r++) begin
          if (r_last[DP]) begin
            r_y[r] <= (r_first[DP] ? '0 : r_acc[r]) + r_tree[DP][r][0];
          end else if (r_first[DP]) begin
            r_acc[r] <= r_tree[DP][r][0];
          end else begin
            r_acc[r] <= r_acc[r] + r_tree[DP][r][0];
          end
        end
      end
    end
  end

endmodule

// File: doc/matvec_mul_fold.md
# matvec_mul_fold

Folded, streaming, signed matrix-vector multiplier that computes y = K·x. The R×C weight matrix K is presented in parallel. The vector x arrives over a valid/ready stream in beats of P elements, so one vector takes C/P beats. Each beat passes through P registered multipliers per row and a registered adder tree. A per-row accumulator sums the beats and hands the result to a valid/ready output register. It is the area-scalable, flow-controlled successor to the fully parallel adder-tree multiplier and sits between the activation stream and the downstream requantisation stage.

## Interface
- R, 8, rows of K (output channels)
- C, 8, columns of K (vector length); C must be a multiple of P
- P, 4, lanes per beat; any value ≥1, padded internally to 2**$clog2(P)
- W_X, 8, signed element width of x
- W_K, 8, signed element width of K
- localparam BEATS = C/P; DP = $clog2(P); W_M = W_X+W_K; W_Y = W_M+$clog2(C)

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, asynchronous, active-high
- k  in  [R][C][W_K] signed  weight matrix; must be stable from the first-beat accept to the last-beat accept of each vector
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat ready
- s_x  in  [P][W_X] signed  beat b carries x[b*P +: P]
- m_valid  out  1  result valid
- m_ready  in  1  result accepted
- m_y  out  [R][W_Y] signed  result vector

## Operation
- Global advance enable: en = !m_valid || m_ready. s_ready = en. A beat is accepted when s_valid && s_ready.
- Beat counter b (0..BEATS-1):
  - increments on each accepted beat
  - wraps to 0 after BEATS-1
  - each accepted beat is tagged first (b==0) and last (b==BEATS-1); with BEATS==1 a beat is both.
- Stage 0, on en: for each r and p, prod[r][p] <= k[r][b*P+p] * s_x[p], sign-extended to W_Y. Padded lanes are 0. A valid bit and the first/last tags travel with the data.
- Stages 1..DP, on en: each tree level registers pairwise sums, as in the parallel tree. The valid bit and tags shift along.
- Accumulate stage, on en with the tree-output valid bit set:
  - first && !last: acc[r] <= psum[r]
  - !first && !last: acc[r] <= acc[r]+psum[r]
  - last: m_y[r] <= (first ? 0 : acc[r]) + psum[r] and m_valid <= 1
- A bubble (s_valid low while en) enters as valid=0. The accumulator does not change for a bubble.
- m_valid clears on m_valid && m_ready unless a new last beat completes in the same cycle, in which case the new result loads and m_valid stays 1.
- When en is low, the whole pipeline, beat counter and accumulator hold.
- Widths: full precision, with no truncation or saturation. W_Y cannot overflow. The worst case C·(−2^(W_X−1))·(−2^(W_K−1)) fits.
- Mid-operation reset (rst high at any time) discards any partial vector. The next accepted beat is beat 0.

## Timing
- Reset values:
  - s_ready 1 (since m_valid 0)
  - m_valid 0
  - m_y all 0
  - b 0, all valid bits 0, acc 0, tree registers 0
- Latency: with no stall, m_valid rises DP+1 edges after the edge that accepts the last beat. At default P=4 that is 3 edges.
- Throughput: one beat per cycle while m_ready is high, i.e. one vector per BEATS cycles, fully back-to-back.
- A stall (m_valid && !m_ready) freezes every stage. m_y stays stable, no beat is accepted, and no partial sum is lost.
- K is sampled only at stage 0. Changing k between vectors (after the last-beat accept) is legal.

## Test plan
- Reset:
  - assert rst mid-stream -> m_valid=0, m_y=0, s_ready=1 immediately, without waiting for a clock edge
  - after release, a fresh vector x=1..8 with all k=1 -> every y=36
- Basic, defaults (R=8, C=8, P=4):
  - k[r][c]=r+1, beat0 x=1,2,3,4, beat1 x=5,6,7,8 -> y[r]=36·(r+1)
  - m_valid rises exactly 3 edges after the beat-1 accept
- Signed extremes:
  - all k=−128, x=−128 -> y=131072
  - all k=127, x=−128 -> y=−130048
  - no wrap in W_Y=19
- Backpressure:
  - two vectors back-to-back, m_ready low for 5 cycles when the first result appears -> s_ready=0 during the stall, m_y holds
  - then both results arrive in order, correct, with no dropped or duplicated beats
- Bubbles: s_valid toggling 1,0,0,1 across the beats of one vector -> same y as the contiguous case, with latency counted from the last accept.
- Corner parameters:
  - P=1, C=3 -> 3 beats per vector, latency 1 edge
  - P=C=3 (padded to 4) -> single beat with first=last, y correct
